// File: rtl/wave_cal_sampler.sv
// Sample-strobe generator plus per-window waveform analysis: DC removal, peak-to-peak,
// and a PAPR figure from a sequential divider that classifies the input as sine/other.
module wave_cal_sampler #(
  parameter int FRE_DIV             = 2499,
  parameter int N                   = 8,
  parameter int SAMPLE_POINTS       = 128,
  parameter int LOG_2_SAMPLE_POINTS = 7,
  parameter int JUDGE_THRESHOLD     = 700
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] data_in_unsigned,
  output logic         sample_en,
  output logic [N-1:0] signal_dc_removed,
  output logic [N-1:0] vpp,
  output logic [31:0]  papr,
  output logic         is_sine_wave
);
  localparam int CW = (FRE_DIV < 2) ? 1 : $clog2(FRE_DIV + 1);
  localparam int IW = (LOG_2_SAMPLE_POINTS < 1) ? 1 : LOG_2_SAMPLE_POINTS;
  localparam int SW = N + LOG_2_SAMPLE_POINTS;
  localparam int PW = 2 * N;
  localparam int QW = PW + LOG_2_SAMPLE_POINTS;

  typedef enum logic {DIV_IDLE, DIV_BUSY} div_state_e;

  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic [IW-1:0] idx_q;
  logic          idx_last;
  logic [N-1:0]  x_q;
  logic          x_vld_q, x_last_q;

  logic [N-1:0]  max_q, min_q, dc_q, sdr_q, vpp_q;
  logic [SW-1:0] sum_q;
  logic [QW-1:0] sumsq_q;
  logic [PW-1:0] peak_q;
  logic          first_win_q;

  logic [N:0]    diff;
  logic [N-1:0]  d_sat;
  logic [PW-1:0] d_ext, d_sq;
  logic [N-1:0]  max_w, min_w, dc_w;
  logic [SW-1:0] sum_w;
  logic [QW-1:0] sumsq_w;
  logic [PW-1:0] peak_w, mean_w;

  div_state_e    state_q, state_d;
  logic [31:0]   dvd_q, quo_step, papr_q;
  logic [PW-1:0] dvs_q, rem_q, rem_sub, rem_step;
  logic [PW:0]   rem_sh;
  logic          rem_ge;
  logic [4:0]    bit_q;
  logic          sine_q;
  logic          win_end, div_start, div_flat, div_done;

  assign sample_en = (div_cnt_q == CW'(FRE_DIV));
  assign div_cnt_d = sample_en ? '0 : div_cnt_q + 1'b1;
  assign idx_last  = (idx_q == IW'(SAMPLE_POINTS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      idx_q     <= '0;
      x_q       <= '0;
      x_vld_q   <= 1'b0;
      x_last_q  <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      x_vld_q   <= sample_en;
      if (sample_en) begin
        x_q      <= data_in_unsigned;
        x_last_q <= idx_last;
        idx_q    <= idx_last ? '0 : idx_q + 1'b1;
      end
    end
  end

  // Difference is N+1 bits; it fits N signed bits only when its top two bits agree.
  assign diff = {1'b0, x_q} - {1'b0, dc_q};
  always_comb begin
    d_sat = diff[N-1:0];
    if (diff[N] != diff[N-1])
      d_sat = diff[N] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
  end
  assign d_ext = {{N{d_sat[N-1]}}, d_sat};
  assign d_sq  = d_ext * d_ext;

  // Window statistics including the sample currently in x_q.
  assign max_w   = (x_q > max_q) ? x_q : max_q;
  assign min_w   = (x_q < min_q) ? x_q : min_q;
  assign sum_w   = sum_q + SW'(x_q);
  assign sumsq_w = sumsq_q + QW'(d_sq);
  assign peak_w  = (d_sq > peak_q) ? d_sq : peak_q;
  assign dc_w    = N'(sum_w >> LOG_2_SAMPLE_POINTS);
  assign mean_w  = PW'(sumsq_w >> LOG_2_SAMPLE_POINTS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_q       <= '0;
      min_q       <= '1;
      sum_q       <= '0;
      sumsq_q     <= '0;
      peak_q      <= '0;
      dc_q        <= '0;
      sdr_q       <= '0;
      vpp_q       <= '0;
      first_win_q <= 1'b1;
    end else if (x_vld_q) begin
      sdr_q <= d_sat;
      if (x_last_q) begin
        vpp_q       <= max_w - min_w;
        dc_q        <= dc_w;
        first_win_q <= 1'b0;
        max_q       <= '0;
        min_q       <= '1;
        sum_q       <= '0;
        sumsq_q     <= '0;
        peak_q      <= '0;
      end else begin
        max_q   <= max_w;
        min_q   <= min_w;
        sum_q   <= sum_w;
        sumsq_q <= sumsq_w;
        peak_q  <= peak_w;
      end
    end
  end

  // The first window after reset only seeds dc_offset, so it never updates papr.
  assign win_end   = x_vld_q & x_last_q & ~first_win_q;
  assign div_start = win_end & (peak_w != '0);
  assign div_flat  = win_end & (peak_w == '0);

  // Restoring divider: dividend shifts out of dvd_q while quotient bits shift in.
  assign rem_sh   = {rem_q, dvd_q[31]};
  assign rem_ge   = (rem_sh >= {1'b0, dvs_q});
  assign rem_sub  = PW'(rem_sh - {1'b0, dvs_q});
  assign rem_step = rem_ge ? rem_sub : rem_sh[PW-1:0];
  assign quo_step = {dvd_q[30:0], rem_ge};

  always_comb begin
    state_d  = state_q;
    div_done = 1'b0;
    if (state_q == DIV_BUSY && bit_q == 5'd31) begin
      state_d  = DIV_IDLE;
      div_done = 1'b1;
    end
    if (div_start) begin
      state_d  = DIV_BUSY;
      div_done = 1'b0;
    end else if (div_flat) begin
      state_d  = DIV_IDLE;
      div_done = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DIV_IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      bit_q   <= '0;
      papr_q  <= '0;
      sine_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (div_start) begin
        dvd_q <= 32'(mean_w) * 32'd1000;
        dvs_q <= peak_w;
        rem_q <= '0;
        bit_q <= '0;
      end else if (state_q == DIV_BUSY) begin
        dvd_q <= quo_step;
        rem_q <= rem_step;
        bit_q <= bit_q + 1'b1;
      end
      if (div_done) begin
        papr_q <= quo_step;
        sine_q <= (quo_step < 32'(JUDGE_THRESHOLD));
      end else if (div_flat) begin
        papr_q <= 32'd1000;
        sine_q <= 1'b0;
      end
    end
  end

  assign signal_dc_removed = sdr_q;
  assign vpp               = vpp_q;
  assign papr              = papr_q;
  assign is_sine_wave      = sine_q;
endmodule

// File: tb/tb_wave_cal_sampler.sv
// Scoreboard bench for wave_cal_sampler: a behavioural window model queues expected
// DC-removed samples and per-window vpp/papr/is_sine results for comparison.
module tb_wave_cal_sampler;
  localparam int FRE_DIV = 7;
  localparam int SP      = 128;
  localparam int LOG2    = 7;
  localparam int THR     = 700;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  data_in = '0;
  logic        sample_en;
  logic [7:0]  sdr;
  logic [7:0]  vpp;
  logic [31:0] papr;
  logic        is_sine;

  wave_cal_sampler #(
    .FRE_DIV(FRE_DIV), .N(8), .SAMPLE_POINTS(SP),
    .LOG_2_SAMPLE_POINTS(LOG2), .JUDGE_THRESHOLD(THR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .data_in_unsigned(data_in), .sample_en(sample_en),
    .signal_dc_removed(sdr), .vpp(vpp), .papr(papr), .is_sine_wave(is_sine)
  );

  always #5 clk = ~clk;

  typedef struct {
    int vpp;
    int papr;
    int sine;
  } win_exp_t;

  int       checks = 0;
  int       errors = 0;
  int       exp_sdr_q[$];
  win_exp_t exp_win_q[$];
  int       win_countdown = 0;

  int m_idx, m_first, m_dc, m_max, m_min, m_sum, m_sumsq, m_peak, m_papr, m_sine;

  function automatic int sat8(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  function automatic int sine127(input int i);
    case (i % 16)
      0: return 127;  1: return 176;  2: return 217;  3: return 244;
      4: return 254;  5: return 244;  6: return 217;  7: return 176;
      8: return 127;  9: return 78;   10: return 37;  11: return 10;
      12: return 0;   13: return 10;  14: return 37;  default: return 78;
    endcase
  endfunction

  function automatic int sine40(input int i);
    case (i % 16)
      0: return 40;  1: return 55;  2: return 68;  3: return 77;
      4: return 80;  5: return 77;  6: return 68;  7: return 55;
      8: return 40;  9: return 25;  10: return 12; 11: return 3;
      12: return 0;  13: return 3;  14: return 12; default: return 25;
    endcase
  endfunction

  function automatic int square(input int i);
    return ((i % 16) < 8) ? 0 : 128;
  endfunction

  task automatic model_clear_window();
    m_max = 0; m_min = 255; m_sum = 0; m_sumsq = 0; m_peak = 0;
  endtask

  task automatic model_reset();
    m_idx = 0; m_first = 1; m_dc = 0; m_papr = 0; m_sine = 0;
    model_clear_window();
    exp_sdr_q.delete();
    exp_win_q.delete();
    win_countdown = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    data_in = '0;
    repeat (3) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    checks++; if (sample_en !== 1'b0) begin errors++; $display("FAIL %s sample_en: got %b required 0", tag, sample_en); end
    checks++; if (sdr !== 8'd0) begin errors++; $display("FAIL %s dc_removed: got %0d required 0", tag, $signed(sdr)); end
    checks++; if (vpp !== 8'd0) begin errors++; $display("FAIL %s vpp: got %0d required 0", tag, vpp); end
    checks++; if (papr !== 32'd0) begin errors++; $display("FAIL %s papr: got %0d required 0", tag, papr); end
    checks++; if (is_sine !== 1'b0) begin errors++; $display("FAIL %s is_sine: got %b required 0", tag, is_sine); end
  endtask

  // Drives one sample on the next strobe, updates the model, then checks the DUT.
  task automatic drive_sample(input int v);
    int       waited;
    int       d;
    int       exp_d;
    logic [7:0] exp_b;
    win_exp_t w;
    waited = 0;
    while (sample_en !== 1'b1 && waited < 2 * (FRE_DIV + 1) + 4) begin
      @(negedge clk);
      waited++;
    end
    if (sample_en !== 1'b1) begin
      checks++; errors++;
      $display("FAIL sample_en_wait: no strobe after %0d clk, required one within %0d", waited, FRE_DIV + 1);
      return;
    end
    data_in = 8'(v);
    d = sat8(v - m_dc);
    exp_sdr_q.push_back(d);
    if (v > m_max) m_max = v;
    if (v < m_min) m_min = v;
    m_sum   += v;
    m_sumsq += d * d;
    if (d * d > m_peak) m_peak = d * d;
    if (m_idx == SP - 1) begin
      w.vpp = m_max - m_min;
      m_dc  = m_sum / SP;
      if (m_first == 0) begin
        if (m_peak == 0) begin
          m_papr = 1000; m_sine = 0;
        end else begin
          m_papr = ((m_sumsq / SP) * 1000) / m_peak;
          m_sine = (m_papr < THR) ? 1 : 0;
        end
      end
      m_first = 0;
      w.papr = m_papr;
      w.sine = m_sine;
      exp_win_q.push_back(w);
      win_countdown = 7;
      model_clear_window();
      m_idx = 0;
    end else begin
      m_idx++;
    end
    @(negedge clk);
    @(negedge clk);
    exp_d = exp_sdr_q.pop_front();
    exp_b = 8'(exp_d);
    checks++;
    if (sdr !== exp_b) begin
      errors++;
      $display("FAIL dc_removed: got %0d required %0d (input %0d)", $signed(sdr), exp_d, v);
    end
    if (exp_win_q.size() > 0) begin
      win_countdown--;
      if (win_countdown == 0) begin
        w = exp_win_q.pop_front();
        $display("window: vpp=%0d papr=%0d is_sine=%0d (expected %0d %0d %0d)",
                 vpp, papr, is_sine, w.vpp, w.papr, w.sine);
        checks++; if (vpp !== 8'(w.vpp)) begin errors++; $display("FAIL window_vpp: got %0d required %0d", vpp, w.vpp); end
        checks++; if (papr !== 32'(w.papr)) begin errors++; $display("FAIL window_papr: got %0d required %0d", papr, w.papr); end
        checks++; if (is_sine !== 1'(w.sine)) begin errors++; $display("FAIL window_is_sine: got %b required %0d", is_sine, w.sine); end
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_sample_period();
    int k;
    int w;
    do_reset();
    k = 0;
    while (sample_en !== 1'b1 && k < 4 * (FRE_DIV + 1)) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k + 1 != FRE_DIV + 1) begin errors++; $display("FAIL first_strobe_edge: got %0d required %0d", k + 1, FRE_DIV + 1); end
    for (int p = 0; p < 3; p++) begin
      w = 0;
      @(negedge clk);
      w++;
      checks++;
      if (sample_en !== 1'b0) begin errors++; $display("FAIL strobe_width: got %b required 0", sample_en); end
      while (sample_en !== 1'b1 && w < 4 * (FRE_DIV + 1)) begin
        @(negedge clk);
        w++;
      end
      checks++;
      if (w != FRE_DIV + 1) begin errors++; $display("FAIL strobe_period: got %0d required %0d", w, FRE_DIV + 1); end
    end
  endtask

  task automatic test_constant();
    do_reset();
    for (int i = 0; i < 3 * SP + 8; i++) drive_sample(100);
    checks++; if (vpp !== 8'd0) begin errors++; $display("FAIL const_vpp: got %0d required 0", vpp); end
    checks++; if (sdr !== 8'd0) begin errors++; $display("FAIL const_dc_removed: got %0d required 0", $signed(sdr)); end
    checks++; if (papr !== 32'd1000) begin errors++; $display("FAIL const_papr: got %0d required 1000", papr); end
    checks++; if (is_sine !== 1'b0) begin errors++; $display("FAIL const_is_sine: got %b required 0", is_sine); end
  endtask

  task automatic test_sine();
    for (int i = 0; i < 3 * SP; i++) drive_sample(sine127(i));
    checks++; if (vpp < 8'd252 || vpp > 8'd254) begin errors++; $display("FAIL sine_vpp_range: got %0d required 252..254", vpp); end
    checks++; if (papr < 32'd460 || papr > 32'd540) begin errors++; $display("FAIL sine_papr_range: got %0d required 460..540", papr); end
    checks++; if (is_sine !== 1'b1) begin errors++; $display("FAIL sine_is_sine: got %b required 1", is_sine); end
  endtask

  task automatic test_square_to_sine();
    for (int i = 0; i < 3 * SP; i++) drive_sample(square(i));
    checks++; if (vpp !== 8'd128) begin errors++; $display("FAIL square_vpp: got %0d required 128", vpp); end
    checks++; if (papr < 32'd990 || papr > 32'd1000) begin errors++; $display("FAIL square_papr_range: got %0d required 990..1000", papr); end
    checks++; if (is_sine !== 1'b0) begin errors++; $display("FAIL square_is_sine: got %b required 0", is_sine); end
    for (int i = 0; i < 2 * SP; i++) drive_sample(sine40(i));
    checks++; if (is_sine !== 1'b1) begin errors++; $display("FAIL switch_is_sine: got %b required 1", is_sine); end
  endtask

  task automatic test_saturation();
    do_reset();
    drive_sample(255);
    checks++; if (sdr !== 8'h7f) begin errors++; $display("FAIL sat_positive: got %0d required 127", $signed(sdr)); end
    for (int i = 1; i < SP; i++) drive_sample(255);
    drive_sample(0);
    checks++; if (sdr !== 8'h80) begin errors++; $display("FAIL sat_negative: got %0d required -128", $signed(sdr)); end
    for (int i = 1; i < SP; i++) drive_sample(0);
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 2 * SP + 60; i++) drive_sample(square(i));
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("reset_mid_window");
    repeat (2) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    for (int i = 0; i < 2 * SP + 8; i++) drive_sample(square(i));
    checks++; if (papr == 32'd0) begin errors++; $display("FAIL papr_after_two_windows: got 0 required nonzero"); end
    for (int i = 2 * SP + 8; i < 3 * SP; i++) drive_sample(square(i));
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("reset_in_division");
    repeat (2) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    for (int i = 0; i < SP + 8; i++) drive_sample(square(i));
    checks++; if (papr !== 32'd0) begin errors++; $display("FAIL papr_after_one_window: got %0d required 0", papr); end
    for (int i = SP + 8; i < 2 * SP + 8; i++) drive_sample(square(i));
    checks++; if (papr !== 32'd1000) begin errors++; $display("FAIL papr_after_restart: got %0d required 1000", papr); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_sample_period();
    test_constant();
    test_sine();
    test_square_to_sine();
    test_saturation();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/wave_cal_sampler.md
WAVE_CAL_SAMPLER -- requirements
Module: wave_cal_sampler

Interface
REQ-001 Parameter FRE_DIV, default 2499: sample_en period is FRE_DIV+1 clk cycles (20 kHz at 50 MHz).
REQ-002 Parameter N, default 8: input/output sample width.
REQ-003 Parameter SAMPLE_POINTS, default 128: samples per analysis window.
REQ-004 Parameter LOG_2_SAMPLE_POINTS, default 7: log2(SAMPLE_POINTS).
REQ-005 Parameter JUDGE_THRESHOLD, default 700: papr threshold for sine decision.
REQ-006 clk  in  1  single system clock, 50 MHz, all logic on rising edge.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 data_in_unsigned  in  N  unsigned ADC sample, sampled only on sample_en.
REQ-009 sample_en  out  1  one-clk-wide sample strobe.
REQ-010 signal_dc_removed  out  N signed  current sample minus window DC estimate, saturated.
REQ-011 vpp  out  N unsigned  max-min of last completed window.
REQ-012 papr  out  32  1000*mean_power/peak_power of last completed window.
REQ-013 is_sine_wave  out  1  1 = sine, 0 = other (square/DC).

Function
REQ-014 Divider: counter 0..FRE_DIV; sample_en=1 for exactly the clk cycle where counter==FRE_DIV, then counter wraps to 0.
REQ-015 On each sample_en: register data_in_unsigned as x; increment window index 0..SAMPLE_POINTS-1, wrapping.
REQ-016 Per window accumulate running max(x), min(x), sum(x) (N+LOG_2_SAMPLE_POINTS bits, no overflow).
REQ-017 dc_offset (internal, N bits) = sum>>LOG_2_SAMPLE_POINTS, latched at window end; used for the whole next window.
REQ-018 signal_dc_removed registered one clk after sample_en = x - dc_offset computed in N+1 bits, saturated to [-128,127].
REQ-019 Per window accumulate d^2 of signal_dc_removed (sum_sq, >=22 bits) and peak_power = max d^2.
REQ-020 At window end (sample_en with index==SAMPLE_POINTS-1, after including that sample): vpp = max-min; mean_power = sum_sq>>LOG_2_SAMPLE_POINTS; start division; clear max/min/sum/sum_sq/peak for next window.
REQ-021 Division: sequential unsigned restoring divider, 32-bit quotient of (mean_power*1000)/peak_power, truncated; completes within 40 clk, well before next sample_en.
REQ-022 On division done (same cycle): papr = quotient; is_sine_wave = (quotient < JUDGE_THRESHOLD).
REQ-023 peak_power==0 (DC input): skip division, papr = 1000, is_sine_wave = 0.
REQ-024 First window after reset only establishes dc_offset: vpp updates, papr/is_sine_wave remain at reset value until end of second window.
REQ-025 papr and is_sine_wave hold between updates; vpp holds between window ends.
REQ-026 sample_en arriving while divider busy is impossible with defaults; if FRE_DIV<40, divider result is discarded and restarted on new window end.

Reset
REQ-027 rst_n low: divider counter, window index, accumulators, dc_offset, divider state cleared immediately; sample_en=0, signal_dc_removed=0, vpp=0, papr=0, is_sine_wave=0.
REQ-028 Reset mid-window or mid-division: partial results discarded; after release first sample_en occurs FRE_DIV+1 clks later and window restarts at index 0 with REQ-024 applying.

Verification
REQ-029 Release reset, count clks -> sample_en pulses every 2500 clk, 1 clk wide, first at clk 2500.
REQ-030 Constant input 100 for 3 windows -> vpp=0, signal_dc_removed=0 from window 2, papr=1000, is_sine_wave=0.
REQ-031 Sine 127+127*sin, 1 ms period, 3 windows -> vpp 252..254, papr 460..540, is_sine_wave=1.
REQ-032 Square 0/128, 1 ms period, 3 windows -> vpp=128, papr 990..1000, is_sine_wave=0; switch to sine 40+40*sin -> is_sine_wave=1 within 2 windows.
REQ-033 dc_offset 0 (window 1) then input 255 -> signal_dc_removed=127; dc_offset 255 then input 0 -> -128.
REQ-034 Assert rst_n low at window index 60 and during division -> all outputs 0 immediately; papr first nonzero only after 2 full windows post-release.
